seq_divider: RTL
================

// Module: seq_divider
// PURPOSE
//  Multi-cycle restoring divider: Q = A / B, R = A % B, one quotient bit per clock.
//  It is the inverse of the combinational add/sub datapath. Each iteration does one
//  trial subtraction on the FullAdder-based add/sub path, then restores on a negative result.
//  Sits beside the add/sub unit in the arithmetic block; controlled by a start/done handshake.
// PARAMETERS
//  WIDTH  5  operand, quotient and remainder width in bits (>=2)
// PORTS
//  clk      in   1      single clock; all state updates on rising edge
//  rst      in   1      synchronous, active-high reset
//  start    in   1      request; sampled only in IDLE
//  A        in   WIDTH  dividend; latched on accepted start
//  B        in   WIDTH  divisor; latched on accepted start
//  busy     out  1      high while iterating (state CALC)
//  done     out  1      one-cycle pulse; Q/R/dz_flag/ov_flag valid from this cycle
//  Q        out  WIDTH  quotient; held until the next accepted start
//  R        out  WIDTH  remainder; held until the next accepted start
//  dz_flag  out  1      divide-by-zero on the last operation; held
//  ov_flag  out  1      signed overflow on the last operation; held; tied 0 without macro
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, Q, R, dz_flag, ov_flag all 0. Takes effect in any state.
//    A reset mid-CALC aborts the operation: no done pulse, and partial results are discarded.
//  FSM: IDLE -(start & B!=0)-> CALC; IDLE -(start & B==0)-> DONE; CALC -(iter==WIDTH-1)-> DONE;
//       DONE -> IDLE unconditionally.
//  Accepting start clears Q, R, dz_flag and ov_flag and latches A and B.
//  start in CALC or DONE is ignored; it is not queued.
//  Iteration (CALC): P = {P[WIDTH-1:0], D[WIDTH-1]}, where P is (WIDTH+1) bits and D shifts left.
//    T = P - {0,B}. If T[WIDTH]==0, then P=T and the shifted-in quotient bit is 1.
//    Otherwise P is kept (restore) and the shifted-in quotient bit is 0.
//  Latency: start high in cycle 0; busy high in cycles 1..WIDTH; done high in cycle WIDTH+1.
//    For the default WIDTH=5, done is high in cycle 6. busy is low during DONE.
//  Divide by zero: done in cycle 1, busy never high; Q = all ones, R = A, dz_flag = 1.
//  All arithmetic is modulo 2^WIDTH. No result bit depends on X when A and B are known.
// CONFIGURATION
//  SEQ_DIVIDER_SIGNED_EN defined: A, B, Q and R are two's complement.
//    Magnitudes are taken as (~x+1) when the MSB is set, then divided unsigned.
//    Q is negated if sign(A)!=sign(B); R takes the sign of A (truncation toward zero).
//    The magnitude/sign fix-ups are registered in the latch and DONE stages, so latency is unchanged.
//    A = -2^(WIDTH-1), B = -1 gives Q = -2^(WIDTH-1) (wrapped), R = 0, ov_flag = 1.
//    Divide by zero gives Q = all ones, R = A, dz_flag = 1.
//  Not defined: purely unsigned; ov_flag tied 0; no sign logic synthesised.
// STRUCTURE
//  Package seq_divider_pkg:
//    typedef div_state_t {IDLE=2'd0, CALC=2'd1, DONE=2'd2}
//    localparam DIV_WIDTH_DEF = 5
//    function twos_neg(x) = ~x + 1
//  Sub-module div_trial_sub: combinational (WIDTH+1)-bit subtractor.
//    Ports P, B -> T, neg. Built as a FullAdder ripple chain with inverted B and carry-in 1.
//  Top holds the FSM, iteration counter ($clog2(WIDTH) bits), P/D/Q registers and flag registers.
// TESTING
//  1. A=13, B=3, start in cycle 0 -> busy in cycles 1..5; done in cycle 6; Q=4, R=1, dz=0.
//  2. A=31, B=1 -> Q=31, R=0. Then A=2, B=31 -> Q=0, R=2.
//     Outputs hold their values between the two operations.
//  3. A=7, B=0 -> done in cycle 1, busy stays 0; Q=31, R=7, dz_flag=1.
//     A following op A=6, B=2 clears dz_flag; Q=3, R=0.
//  4. A=20, B=6 started; start re-pulsed in cycles 2 and 6 with A=9, B=9.
//     Both re-pulses are ignored; Q=3, R=2; a single done pulse.
//  5. rst asserted in cycle 3 of A=25, B=4 -> next cycle busy=0, Q=R=0, no done pulse.
//     A new start with A=25, B=4 then gives Q=6, R=1 at cycle 6.
//  6. SEQ_DIVIDER_SIGNED_EN: A=-13 (10011), B=3 -> Q=11100 (-4), R=11111 (-1).
//     A=10000, B=11111 -> Q=10000, R=0, ov_flag=1.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN (two's complement operands).
package seq_divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int DIV_WIDTH_DEF = 5;

   // Two's complement negation; callers cast the result back to their own width.
   function automatic logic [31:0] twos_neg(input logic [31:0] x);
      return ~x + 32'd1;
   endfunction

endpackage

// File: rtl/seq_divider_trial_sub.sv
// Trial subtractor for one restoring-division step: T = P - {0,B}.
// Built as a ripple chain of full adders fed with ~{0,B} and a carry-in of 1.
// The (WIDTH+1)-bit difference is split into its low WIDTH bits (T) and its
// sign bit (neg); neg high means the trial went negative and must be restored.
module div_trial_sub
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEF
) (
   input  logic [WIDTH:0]   P,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] T,
   output logic             neg
);

   logic [WIDTH:0] bInv;
   logic [WIDTH:0] carry;
   logic [WIDTH:0] sum;

   assign bInv     = ~{1'b0, B};
   assign carry[0] = 1'b1;

   // One full adder per bit; the final stage needs no carry out.
   for (genvar i = 0; i <= WIDTH; i++) begin : gFullAdder
      assign sum[i] = P[i] ^ bInv[i] ^ carry[i];
      if (i < WIDTH) begin : gCarry
         assign carry[i+1] = (P[i] & bInv[i]) | (carry[i] & (P[i] ^ bInv[i]));
      end
   end

   assign T   = sum[WIDTH-1:0];
   assign neg = sum[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: Q = A / B, R = A % B, one quotient bit per clock.
// start/done handshake; Q/R/flags are held until the next accepted start.
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN selects two's complement operands,
// with magnitudes taken on latch and sign fix-ups applied on the final step.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             dz_flag,
   output logic             ov_flag
);

   localparam int              CW        = $clog2(WIDTH);
   localparam logic [CW-1:0]   LAST_ITER = CW'(WIDTH - 1);

   div_state_t       state_q;
   logic [CW-1:0]    iterCnt_q;
   logic [WIDTH-1:0] partRem_q;
   logic [WIDTH-1:0] dividend_q;
   logic [WIDTH-1:0] divisor_q;
   logic [WIDTH-1:0] quot_q;
   logic [WIDTH-1:0] rem_q;
   logic             busy_q;
   logic             done_q;
   logic             dz_q;

   logic [WIDTH:0]   partShift;
   logic [WIDTH-1:0] trialRem;
   logic             trialNeg;
   logic [WIDTH-1:0] partRem_d;
   logic [WIDTH-1:0] dividend_d;
   logic [WIDTH-1:0] quotOut;
   logic [WIDTH-1:0] remOut;
   logic [WIDTH-1:0] aMag;
   logic [WIDTH-1:0] bMag;

`ifdef SEQ_DIVIDER_SIGNED_EN
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
   logic negQuot_q;
   logic negRem_q;
   logic ovPend_q;
   logic ov_q;
`endif

   // Bring the next dividend bit into the partial remainder and try subtracting B.
   assign partShift = {partRem_q, dividend_q[WIDTH-1]};

   div_trial_sub #(
      .WIDTH (WIDTH)
   ) uTrialSub (
      .P   (partShift),
      .B   (divisor_q),
      .T   (trialRem),
      .neg (trialNeg)
   );

   // Restore on a negative trial; the dividend register doubles as the quotient shifter.
   always_comb begin
      partRem_d  = trialNeg ? partShift[WIDTH-1:0] : trialRem;
      dividend_d = {dividend_q[WIDTH-2:0], ~trialNeg};
      quotOut    = dividend_d;
      remOut     = partRem_d;
      aMag       = A;
      bMag       = B;
`ifdef SEQ_DIVIDER_SIGNED_EN
      if (A[WIDTH-1]) aMag = WIDTH'(twos_neg(32'(A)));
      if (B[WIDTH-1]) bMag = WIDTH'(twos_neg(32'(B)));
      if (negQuot_q)  quotOut = WIDTH'(twos_neg(32'(dividend_d)));
      if (negRem_q)   remOut  = WIDTH'(twos_neg(32'(partRem_d)));
`endif
   end

   // Control FSM with registered handshake outputs and result/flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         iterCnt_q  <= '0;
         partRem_q  <= '0;
         dividend_q <= '0;
         divisor_q  <= '0;
         quot_q     <= '0;
         rem_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         dz_q       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
         negQuot_q  <= 1'b0;
         negRem_q   <= 1'b0;
         ovPend_q   <= 1'b0;
         ov_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  quot_q <= '0;
                  rem_q  <= '0;
                  dz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                  ov_q   <= 1'b0;
`endif
                  if (B == '0) begin
                     quot_q  <= '1;
                     rem_q   <= A;
                     dz_q    <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     dividend_q <= aMag;
                     divisor_q  <= bMag;
                     partRem_q  <= '0;
                     iterCnt_q  <= '0;
                     busy_q     <= 1'b1;
                     state_q    <= CALC;
`ifdef SEQ_DIVIDER_SIGNED_EN
                     negQuot_q  <= A[WIDTH-1] ^ B[WIDTH-1];
                     negRem_q   <= A[WIDTH-1];
                     ovPend_q   <= (A == MIN_VAL) && (B == '1);
`endif
                  end
               end
            end
            CALC: begin
               partRem_q  <= partRem_d;
               dividend_q <= dividend_d;
               iterCnt_q  <= iterCnt_q + CW'(1);
               if (iterCnt_q == LAST_ITER) begin
                  quot_q  <= quotOut;
                  rem_q   <= remOut;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
`ifdef SEQ_DIVIDER_SIGNED_EN
                  ov_q    <= ovPend_q;
`endif
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign Q       = quot_q;
   assign R       = rem_q;
   assign dz_flag = dz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
   assign ov_flag = ov_q;
`else
   assign ov_flag = 1'b0;
`endif

endmodule
